// File: rtl/sseg_scan_n_if.sv
// sseg_scan_n_if -- signal bundle between board logic and the seven-segment
// scanner.
//   master : board side; drives value/dp_in/blank_in/lz_sup/brightness
//            (and blink_in when SSEG_BLINK_EN is defined), receives the pins.
//   slave  : scanner side; drives seg/an/dp/digit_idx/scan_tick.
// Optional macro: SSEG_BLINK_EN adds blink_in.
interface sseg_scan_n_if #(
    parameter int DIGITS   = 4,
    parameter int PWM_BITS = 4
);
    localparam int IDX_W = $clog2(DIGITS);

    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
`ifdef SSEG_BLINK_EN
    logic [DIGITS-1:0]   blink_in;
`endif
    logic                lz_sup;
    logic [PWM_BITS-1:0] brightness;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                dp;
    logic [IDX_W-1:0]    digit_idx;
    logic                scan_tick;

    modport master (
`ifdef SSEG_BLINK_EN
        output blink_in,
`endif
        output value, dp_in, blank_in, lz_sup, brightness,
        input  seg, an, dp, digit_idx, scan_tick
    );

    modport slave (
`ifdef SSEG_BLINK_EN
        input  blink_in,
`endif
        input  value, dp_in, blank_in, lz_sup, brightness,
        output seg, an, dp, digit_idx, scan_tick
    );
endinterface

// File: rtl/sseg_scan_n.sv
// sseg_scan_n -- time-multiplexed N-digit seven-segment scanner with built-in
// refresh prescaler, leading-zero suppression, PWM brightness, per-scan input
// snapshot and a one-cycle ghosting guard at the start of every digit slot.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sseg_scan_n_if.slave
//              in : value (hex nibbles, digit 0 rightmost), dp_in, blank_in,
//                   lz_sup, brightness [, blink_in]
//              out: seg (active-low, seg[0]=a), an (active-low), dp
//                   (active-low), digit_idx, scan_tick
// Optional macro: SSEG_BLINK_EN -- blink_in forces digits dark on alternate
// groups of BLINK_SCANS scans.
module sseg_scan_n #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int PWM_BITS    = 4,
    parameter int BLINK_SCANS = 64
) (
    input  logic         clk,
    input  logic         rst,
    sseg_scan_n_if.slave bus
);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
        $error("sseg_scan_n: DIGITS must be 2..8");
    end
    if (REFRESH_DIV < (1 << PWM_BITS) + 1) begin : g_bad_div
        $error("sseg_scan_n: REFRESH_DIV too small for PWM_BITS");
    end
    if (BLINK_SCANS < 1) begin : g_bad_blink
        $error("sseg_scan_n: BLINK_SCANS must be >= 1");
    end

    logic [PRE_W-1:0]    pre;
    logic [IDX_W-1:0]    idx;
    logic                tick;
    logic                primed;   // low only until the first edge after reset
    logic [4*DIGITS-1:0] value_s;
    logic [DIGITS-1:0]   dp_s, blank_s, supp;
    logic                lz_s;
    logic                slot_end, scan_end, snap_en, blink_ok, en;
    logic [3:0]          nib;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   an_q;
    logic                dp_q;

    assign slot_end = (pre == PRE_LAST);
    assign scan_end = slot_end && (idx == IDX_LAST);
    // Shadow registers reload only when a new scan starts, so a frame is
    // always built from one coherent set of inputs.
    assign snap_en  = !primed || scan_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre    <= '0;
            idx    <= '0;
            tick   <= 1'b0;
            primed <= 1'b0;
        end else begin
            pre    <= slot_end ? '0 : pre + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            tick   <= scan_end;
            primed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_s <= '0;
            dp_s    <= '0;
            blank_s <= '0;
            lz_s    <= 1'b0;
        end else if (snap_en) begin
            value_s <= bus.value;
            dp_s    <= bus.dp_in;
            blank_s <= bus.blank_in;
            lz_s    <= bus.lz_sup;
        end
    end

    // Digit i>=1 is suppressed when it and every digit to its left are zero.
    always_comb begin
        supp = '0;
        for (int i = 1; i < DIGITS; i++) begin
            supp[i] = lz_s;
            for (int j = i; j < DIGITS; j++)
                if (value_s[4*j +: 4] != 4'h0) supp[i] = 1'b0;
        end
    end

`ifdef SSEG_BLINK_EN
    localparam int BC_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    logic [BC_W-1:0] blink_cnt;
    logic            blink_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BC_W'(BLINK_SCANS - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blink_ok = !(blink_phase && bus.blink_in[idx]);
`else
    assign blink_ok = 1'b1;
`endif

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0:    decode = 7'b1000000;
            4'h1:    decode = 7'b1111001;
            4'h2:    decode = 7'b0100100;
            4'h3:    decode = 7'b0110000;
            4'h4:    decode = 7'b0011001;
            4'h5:    decode = 7'b0010010;
            4'h6:    decode = 7'b0000010;
            4'h7:    decode = 7'b1111000;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0010000;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b0000011;
            4'hC:    decode = 7'b1000110;
            4'hD:    decode = 7'b0100001;
            4'hE:    decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    assign nib = value_s[{idx, 2'b00} +: 4];
    // pre == 0 is the ghost guard: every slot opens with all anodes off.
    assign en  = !blank_s[idx] && !supp[idx] && (pre != '0) &&
                 (pre[PWM_BITS-1:0] < bus.brightness) && blink_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= '1;
            dp_q  <= 1'b1;
        end else if (en) begin
            an_q  <= ~(DIGITS'(1) << idx);
            seg_q <= decode(nib);
            dp_q  <= ~dp_s[idx];
        end else begin
            an_q  <= '1;
            seg_q <= '1;
            dp_q  <= 1'b1;
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.digit_idx = idx;
    assign bus.scan_tick = tick;
endmodule

// File: tb/tb_sseg_scan_n.sv
// tb_sseg_scan_n -- self-checking bench for sseg_scan_n (DIGITS=4,
// REFRESH_DIV=20, PWM_BITS=2, BLINK_SCANS=2). A cycle-count reference model
// derives every expected output from the number of clock edges since reset;
// directed and random stimulus phases exercise it.
module tb_sseg_scan_n;
    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 20;
    localparam int PWM_BITS    = 2;
    localparam int BLINK_SCANS = 2;
    localparam int SCAN        = DIGITS * REFRESH_DIV;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    sseg_scan_n_if #(.DIGITS(DIGITS), .PWM_BITS(PWM_BITS)) bus ();

    sseg_scan_n #(
        .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV),
        .PWM_BITS(PWM_BITS), .BLINK_SCANS(BLINK_SCANS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    int          n;            // clock edges since reset release
    int          m_pre, m_d;
    logic        m_on, m_primed, m_lz;
    logic [15:0] m_val;
    logic [3:0]  m_dp, m_blank;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_tick;
    int          e_idx;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            n = 0; m_primed = 1'b0;
            m_val = '0; m_dp = '0; m_blank = '0; m_lz = 1'b0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 0; e_tick = 1'b0;
        end else begin
            m_pre = n % REFRESH_DIV;
            m_d   = (n / REFRESH_DIV) % DIGITS;
            m_on  = (m_pre != 0) && ((m_pre % (1 << PWM_BITS)) < int'(bus.brightness)) &&
                    !m_blank[m_d] &&
                    !(m_d > 0 && m_lz && ((m_val >> (4 * m_d)) == 16'h0));
`ifdef SSEG_BLINK_EN
            if (n > 0 && ((((n - 1) / SCAN) / BLINK_SCANS) % 2) == 1 && bus.blink_in[m_d])
                m_on = 1'b0;
`endif
            e_an  = m_on ? 4'(~(4'b0001 << m_d)) : 4'hF;
            e_seg = m_on ? seg_tab[(m_val >> (4 * m_d)) & 16'hF] : 7'h7F;
            e_dp  = m_on ? !m_dp[m_d] : 1'b1;
            if (!m_primed || ((n + 1) % SCAN) == 0) begin
                m_val = bus.value; m_dp = bus.dp_in; m_blank = bus.blank_in; m_lz = bus.lz_sup;
            end
            m_primed = 1'b1;
            n++;
            e_idx  = (n / REFRESH_DIV) % DIGITS;
            e_tick = (n % SCAN) == 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        chk("an",        32'(bus.an),        32'(e_an));
        chk("seg",       32'(bus.seg),       32'(e_seg));
        chk("dp",        32'(bus.dp),        32'(e_dp));
        chk("digit_idx", 32'(bus.digit_idx), 32'(e_idx));
        chk("scan_tick", 32'(bus.scan_tick), 32'(e_tick));
        chk("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic apply(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                         input logic lz, input logic [1:0] br, input int k);
        @(negedge clk);
        bus.value = v; bus.dp_in = d; bus.blank_in = b; bus.lz_sup = lz; bus.brightness = br;
        cyc(k);
    endtask

    initial begin
        bus.value = 16'h12AF; bus.dp_in = '0; bus.blank_in = '0;
        bus.lz_sup = 1'b0; bus.brightness = 2'd3;
`ifdef SSEG_BLINK_EN
        bus.blink_in = '0;
`endif
        #1 rst = 1'b1;
        cyc(2);
        rst = 1'b0;                         // released on a falling edge

        // hand-computed pins: k = edges since release
        cyc(1);  chk("lit_k1_an",  32'(bus.an),  32'h0000000F);          // slot guard
        cyc(1);  chk("lit_k2_an",  32'(bus.an),  32'h0000000E);
                 chk("lit_k2_seg", 32'(bus.seg), 32'h0000000E);          // F
        cyc(20); chk("lit_k22_an",  32'(bus.an),  32'h0000000D);
                 chk("lit_k22_seg", 32'(bus.seg), 32'h00000008);         // A
        cyc(20); chk("lit_k42_an",  32'(bus.an),  32'h0000000B);
                 chk("lit_k42_seg", 32'(bus.seg), 32'h00000024);         // 2
        cyc(20); chk("lit_k62_an",  32'(bus.an),  32'h00000007);
                 chk("lit_k62_seg", 32'(bus.seg), 32'h00000079);         // 1
        cyc(18); chk("lit_k80_tick", 32'(bus.scan_tick), 32'd1);
        cyc(2);  chk("lit_k82_an",  32'(bus.an),  32'h0000000E);

        // asynchronous reset mid-slot: outputs dark before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("async_an",  32'(bus.an),  32'h0000000F);
        chk("async_seg", 32'(bus.seg), 32'h0000007F);
        chk("async_dp",  32'(bus.dp),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        cyc(19); chk("lit_k19_idx", 32'(bus.digit_idx), 32'd0);
        cyc(1);  chk("lit_k20_idx", 32'(bus.digit_idx), 32'd1);

        // directed phases
        apply(16'h0050, 4'b0000, 4'b0000, 1'b1, 2'd3, 200);
        apply(16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3, 200);
        apply(16'h1111, 4'b0000, 4'b0000, 1'b0, 2'd3, 110);
        apply(16'h2222, 4'b0000, 4'b0000, 1'b0, 2'd3, 200);   // changes mid-scan
        apply(16'h5678, 4'b0100, 4'b0000, 1'b0, 2'd3, 200);
        apply(16'h5678, 4'b0000, 4'b0001, 1'b0, 2'd3, 200);
        apply(16'h9ABC, 4'b1111, 4'b0000, 1'b0, 2'd1, 200);
        apply(16'h9ABC, 4'b0000, 4'b0000, 1'b0, 2'd0, 200);
        apply(16'h0D0E, 4'b1010, 4'b0000, 1'b1, 2'd2, 200);   // dp on suppressed digit
`ifdef SSEG_BLINK_EN
        bus.blink_in = 4'b1000;
        apply(16'h4321, 4'b0000, 4'b0000, 1'b0, 2'd3, 700);
`endif

        // random phases
        for (int p = 0; p < 40; p++) begin
`ifdef SSEG_BLINK_EN
            bus.blink_in = 4'($urandom);
`endif
            apply(16'($urandom) >> $urandom_range(0, 16), 4'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                  1'($urandom), 2'($urandom), $urandom_range(1, 250));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sseg_scan_n.md
Name: sseg_scan_n

Overview:
- Parametrised, time-multiplexed N-digit seven-segment scanner with an integrated refresh prescaler.
- Accepts a packed hex word plus per-digit decimal-point and blank masks.
- Adds leading-zero suppression, PWM brightness, a scan-coherent input snapshot and an inter-digit ghosting guard.
- Sits between the board switch/data logic and the Basys3-style segment/anode pins; replaces separate clock-divider, digit-select, nibble-mux and decoder blocks.

Parameters:
- DIGITS, 4, number of digits scanned; legal values 2..8.
- REFRESH_DIV, 100000, clk cycles per digit slot; must be ≥ 2^PWM_BITS + 1.
- PWM_BITS, 4, width of the brightness control.
- BLINK_SCANS, 64, full scans per blink half-period; used only with SSEG_BLINK_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- value  in  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal-point request per digit, active-high.
- blank_in  in  DIGITS  force digit dark, active-high.
- lz_sup  in  1  leading-zero suppression enable.
- brightness  in  PWM_BITS  on-duty in 1/2^PWM_BITS steps.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- an  out  DIGITS  anodes, active-low.
- dp  out  1  decimal point, active-low.
- digit_idx  out  $clog2(DIGITS)  digit currently driven.
- scan_tick  out  1  one-cycle pulse when digit_idx wraps from DIGITS-1 to 0.

Behaviour:
- Single clock domain. rst is asynchronous and active-high; every register clears on assertion.
- Reset values:
  - prescaler = 0, digit_idx = 0, scan_tick = 0.
  - Snapshot registers = 0.
  - an = all ones, seg = 7'b1111111, dp = 1.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - At the terminal count, digit_idx increments next cycle, wrapping DIGITS-1 → 0.
  - scan_tick is high for the single cycle in which digit_idx becomes 0.
  - The first increment after reset occurs REFRESH_DIV cycles after rst deasserts.
- Snapshot:
  - value, dp_in, blank_in and lz_sup are sampled into shadow registers on the same edge that digit_idx wraps to 0, and once on the first edge after reset.
  - Changes inside a scan never tear a frame.
- Leading-zero suppression:
  - Digit i (i ≥ 1) is suppressed when snapshot lz_sup = 1 and every snapshot nibble from DIGITS-1 down to i is 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - A suppressed digit shows no dp even if dp_in is set.
- Digit enable: en = !blank[idx] && !suppressed[idx] && ghost_ok && pwm_on.
  - ghost_ok = 0 when prescaler = 0, i.e. the first cycle of every slot drives all anodes off.
  - pwm_on = (prescaler mod 2^PWM_BITS) < brightness.
  - brightness = 0 → always dark.
  - Max brightness → dark 1 of every 2^PWM_BITS cycles.
- Outputs:
  - Registered with one cycle latency from prescaler/digit_idx.
  - When en: an = ~(1 << idx), seg = decode(nibble[idx]), dp = ~dp_snap[idx].
  - Otherwise: an = all ones, seg = all ones, dp = 1.
- Decode, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-scan: outputs go dark immediately (asynchronous); scanning restarts from digit 0.
- At most one bit of an is ever 0.

Optional Feature:
- SSEG_BLINK_EN defined:
  - Adds input port blink_in [DIGITS].
  - Adds a blink counter stepped by scan_tick, toggling blink_phase every BLINK_SCANS scans; blink_phase resets to 0 (visible).
  - When blink_phase = 1, digits with blink_in set are forced dark.
- Undefined: no blink_in port, no counter, and behaviour is identical to the above.

Test Plan (DIGITS=4, REFRESH_DIV=20, PWM_BITS=2, BLINK_SCANS=2):
- Reset: rst pulsed high mid-slot → an=4'b1111, seg=7'h7F and dp=1 in the same cycle, without waiting for a clock edge; after release, digit_idx=0 and the first increment comes 20 cycles later.
- Scan: value=16'h12AF, brightness=3, lz_sup=0, masks 0:
  - an cycles 1110→1101→1011→0111, segs F,A,2,1.
  - scan_tick pulses every 80 cycles.
  - an=1111 on each slot's first cycle.
- Suppression: value=16'h0050, lz_sup=1 → digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0; value=0 → only digit 0 lit, showing 0.
- Snapshot and dp/blank:
  - value changes 16'h1111→16'h2222 mid-scan → no mixed frame; new value appears from the next digit-0 slot.
  - dp_in=4'b0100 → dp=0 only during the digit-2 slot.
  - blank_in=4'b0001 → digit 0 never lit.
- PWM: brightness=1 → an active 1 of every 4 cycles within a slot; brightness=0 → an=1111 always.
- Blink (SSEG_BLINK_EN): blink_in=4'b1000 → digit 3 lit for 2 scans, dark for 2 scans, repeating; other digits unaffected.
